// File: rtl/decoder_seq_n.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_seq_n
//  Description : Registered one-hot decoder (SEL_W -> 2**SEL_W) with a
//                handshaked DIRECT mode and a SCAN mode that walks a single
//                hot bit across all outputs with a programmable dwell time.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_seq_n #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] d,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W = 2 ** SEL_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  // Bit 0 set; shifted left by an index to form every one-hot code.
  localparam logic [OUT_W-1:0] ONE_HOT_LSB = {{(OUT_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [OUT_W-1:0]   d_q,     d_d;
  logic [SEL_W-1:0]   idx_q,   idx_d;
  logic               wrap_q,  wrap_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;

  logic [SEL_W-1:0]   w_idx_next;

  // Next scan position wraps naturally at OUT_W because idx is SEL_W wide.
  assign w_idx_next = idx_q + SEL_W'(1);

  // Handshake is only offered while settled in DIRECT and still asked to be there;
  // rst_n gates it so the block never claims a transfer while being reset.
  assign sel_ready = rst_n && en && !mode && (state_q == ST_DIRECT);

  // Next-state and output computation; d is only ever loaded with zero or a
  // single shifted bit, so it can never become multi-hot.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;

    if (!en) begin
      state_d = ST_IDLE;
      d_d     = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (!mode) begin
      // Entering DIRECT keeps whatever d/idx were showing until a select lands.
      state_d = ST_DIRECT;
      cnt_d   = '0;
      if (sel_valid && sel_ready) begin
        d_d   = ONE_HOT_LSB << sel;
        idx_d = sel;
      end
    end else begin
      state_d = ST_SCAN;
      if (state_q != ST_SCAN) begin
        // Fresh scan always starts at position 0 without a wrap pulse.
        d_d   = ONE_HOT_LSB;
        idx_d = '0;
        cnt_d = '0;
      end else if (cnt_q == dwell) begin
        cnt_d  = '0;
        idx_d  = w_idx_next;
        d_d    = ONE_HOT_LSB << w_idx_next;
        wrap_d = &idx_q;
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_seq_n
//  Description : Directed self-checking bench for decoder_seq_n (SEL_W=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_seq_n;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [2:0] sel;
  logic       sel_valid;
  logic       sel_ready;
  logic [7:0] dwell;
  logic [7:0] d;
  logic [2:0] idx;
  logic       wrap;

  int total;
  int bad;

  logic [7:0] hot [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  decoder_seq_n #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .dwell     (dwell),
    .d         (d),
    .idx       (idx),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Zero or exactly one bit set.
  task automatic chk_onehot(input string tag);
    logic ok;
    ok = ((d & (d - 8'd1)) == 8'd0);
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  // Step until idx reaches target, with a bounded number of cycles.
  task automatic wait_idx(input logic [2:0] target);
    int n;
    n = 0;
    while (idx !== target && n < 40) begin
      tick();
      n++;
    end
    chk("wait_idx", {29'd0, idx}, {29'd0, target});
  endtask

  initial begin
    int k;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    en        = 1'b1;
    mode      = 1'b1;
    sel       = 3'd0;
    sel_valid = 1'b0;
    dwell     = 8'd2;

    // 1. reset dominates en=1/mode=1
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_d",     {24'd0, d},         32'h0);
      chk("rst_idx",   {29'd0, idx},       32'h0);
      chk("rst_wrap",  {31'd0, wrap},      32'h0);
      chk("rst_ready", {31'd0, sel_ready}, 32'h0);
    end

    // 2. DIRECT single accept from IDLE
    rst_n = 1'b1;
    mode  = 1'b0;
    tick();
    chk("dir_entry_d",     {24'd0, d},         32'h0);
    chk("dir_entry_ready", {31'd0, sel_ready}, 32'h1);
    sel       = 3'd5;
    sel_valid = 1'b1;
    tick();
    chk("dir5_d",   {24'd0, d},   32'h20);
    chk("dir5_idx", {29'd0, idx}, 32'h5);
    sel_valid = 1'b0;
    sel       = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dir5_hold_d",   {24'd0, d},   32'h20);
      chk("dir5_hold_idx", {29'd0, idx}, 32'h5);
    end

    // 3. back-to-back sweep 0..7
    sel_valid = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      chk("sweep_d",   {24'd0, d},   {24'd0, hot[s]});
      chk("sweep_idx", {29'd0, idx}, s);
      chk_onehot("sweep_onehot");
    end
    sel_valid = 1'b0;

    // 4. SCAN with dwell=2: three cycles per position, wrap pulse on return to 0
    mode  = 1'b1;
    dwell = 8'd2;
    for (k = 0; k < 51; k++) begin
      tick();
      chk("scan_d",    {24'd0, d},    {24'd0, hot[(k / 3) % 8]});
      chk("scan_idx",  {29'd0, idx},  (k / 3) % 8);
      chk("scan_wrap", {31'd0, wrap}, ((k == 24) || (k == 48)) ? 32'h1 : 32'h0);
      chk("scan_ready",{31'd0, sel_ready}, 32'h0);
      chk_onehot("scan_onehot");
    end

    // 5. drop en mid-scan at idx=4, then restart
    wait_idx(3'd4);
    en = 1'b0;
    tick();
    chk("en_off_d",    {24'd0, d},    32'h0);
    chk("en_off_idx",  {29'd0, idx},  32'h0);
    chk("en_off_wrap", {31'd0, wrap}, 32'h0);
    en = 1'b1;
    tick();
    chk("restart_d",    {24'd0, d},    32'h01);
    chk("restart_idx",  {29'd0, idx},  32'h0);
    chk("restart_wrap", {31'd0, wrap}, 32'h0);

    // 6a. reset mid-scan at idx=3
    wait_idx(3'd3);
    rst_n = 1'b0;
    tick();
    chk("midrst_d",   {24'd0, d},   32'h0);
    chk("midrst_idx", {29'd0, idx}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_d", {24'd0, d}, 32'h01);

    // 6b. switch to DIRECT at idx=3: hold scan value until an accept
    wait_idx(3'd3);
    mode = 1'b0;
    tick();
    chk("sw_hold_d",   {24'd0, d},   32'h08);
    chk("sw_hold_idx", {29'd0, idx}, 32'h3);
    tick();
    chk("sw_hold2_d",  {24'd0, d},         32'h08);
    chk("sw_ready",    {31'd0, sel_ready}, 32'h1);
    sel       = 3'd6;
    sel_valid = 1'b1;
    tick();
    chk("sw_acc_d",   {24'd0, d},   32'h40);
    chk("sw_acc_idx", {29'd0, idx}, 32'h6);
    sel_valid = 1'b0;

    // 6c. dwell=0 advances every cycle
    dwell = 8'd0;
    mode  = 1'b1;
    for (k = 0; k < 10; k++) begin
      tick();
      chk("dw0_d",    {24'd0, d},    {24'd0, hot[k % 8]});
      chk("dw0_wrap", {31'd0, wrap}, (k == 8) ? 32'h1 : 32'h0);
      chk_onehot("dw0_onehot");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
